// File: rtl/ib_ram_update_ctrl.sv
// Iteration-update sequencer: fetches one iteration's LUT pages from the LUT store
// and writes them into the selected frame half of the IB-LUT RAM.
module ib_ram_update_ctrl #(
    parameter int unsigned LUT_PORT_SIZE   = 1,
    parameter int unsigned BANK_NUM        = 2,
    parameter int unsigned ENTRY_ADDR      = 5,
    parameter int unsigned MULTI_FRAME_NUM = 2,
    parameter int unsigned ITER_WIDTH      = 5,
    parameter int unsigned MAX_ITER        = 10,
    localparam int unsigned FRM_W          = $clog2(MULTI_FRAME_NUM),
    localparam int unsigned PAGE_W         = ENTRY_ADDR - FRM_W,
    localparam int unsigned DATA_W         = LUT_PORT_SIZE * BANK_NUM
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic                         update_req,
    input  logic [ITER_WIDTH-1:0]        update_iter,
    input  logic [FRM_W-1:0]             update_frame,
    output logic                         update_busy,
    output logic                         update_done,
    output logic                         iter_err,
    output logic                         req_dropped,
    output logic                         rom_rd_en,
    output logic [ITER_WIDTH+PAGE_W-1:0] rom_rd_addr,
    input  logic [DATA_W-1:0]            rom_rd_data,
    input  logic                         rom_rd_valid,
    output logic [ENTRY_ADDR-1:0]        page_addr_ram,
    output logic [DATA_W-1:0]            ram_write_data_1,
    output logic                         ib_ram_we
);

    localparam logic [PAGE_W-1:0] LastPage = {PAGE_W{1'b1}};

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StWrite, StDone} state_e;

    state_e                         state_q, state_d;
    logic [ITER_WIDTH-1:0]          iter_q, iter_d;
    logic [FRM_W-1:0]               frame_q, frame_d;
    logic [PAGE_W-1:0]              page_q, page_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           drop_q, drop_d;
    logic                           rom_en_q, rom_en_d;
    logic [ITER_WIDTH+PAGE_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ENTRY_ADDR-1:0]          ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]              ram_data_q, ram_data_d;
    logic                           we_q, we_d;

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        frame_d    = frame_q;
        page_d     = page_q;
        data_d     = data_q;
        err_d      = 1'b0;
        drop_d     = update_req && (state_q != StIdle);
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        unique case (state_q)
            StIdle: begin
                if (update_req) begin
                    if (32'(update_iter) < MAX_ITER) begin
                        iter_d  = update_iter;
                        frame_d = update_frame;
                        page_d  = '0;
                        state_d = StFetch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                if (rom_rd_valid) begin
                    data_d  = rom_rd_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (page_q == LastPage) begin
                    state_d = StDone;
                end else begin
                    page_d  = page_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        rom_en_d = (state_d == StFetch);
        we_d     = (state_d == StWrite);
        if (rom_en_d) begin
            rom_addr_d = {iter_d, page_d};
        end
        if (we_d) begin
            ram_addr_d = {frame_d, page_d};
            ram_data_d = data_d;
        end
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            iter_q     <= '0;
            frame_q    <= '0;
            page_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            frame_q    <= frame_d;
            page_q     <= page_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            we_q       <= we_d;
        end
    end

    assign update_busy      = busy_q;
    assign update_done      = done_q;
    assign iter_err         = err_q;
    assign req_dropped      = drop_q;
    assign rom_rd_en        = rom_en_q;
    assign rom_rd_addr      = rom_addr_q;
    assign page_addr_ram    = ram_addr_q;
    assign ram_write_data_1 = ram_data_q;
    assign ib_ram_we        = we_q;

endmodule

// File: tb/tb_ib_ram_update_ctrl.sv
// Scoreboard bench: stimulus pushes expected ROM reads, RAM writes and pulses with their
// cycle numbers; a negedge monitor pops and compares whenever the DUT shows an event.
module tb_ib_ram_update_ctrl;

    localparam int PAGES = 16;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       update_req = 1'b0;
    logic [4:0] update_iter = '0;
    logic [0:0] update_frame = '0;
    logic       update_busy, update_done, iter_err, req_dropped;
    logic       rom_rd_en;
    logic [8:0] rom_rd_addr;
    logic [1:0] rom_rd_data = '0;
    logic       rom_rd_valid = 1'b0;
    logic [4:0] page_addr_ram;
    logic [1:0] ram_write_data_1;
    logic       ib_ram_we;

    ib_ram_update_ctrl dut (
        .write_clk        (clk),
        .rst              (rst),
        .update_req       (update_req),
        .update_iter      (update_iter),
        .update_frame     (update_frame),
        .update_busy      (update_busy),
        .update_done      (update_done),
        .iter_err         (iter_err),
        .req_dropped      (req_dropped),
        .rom_rd_en        (rom_rd_en),
        .rom_rd_addr      (rom_rd_addr),
        .rom_rd_data      (rom_rd_data),
        .rom_rd_valid     (rom_rd_valid),
        .page_addr_ram    (page_addr_ram),
        .ram_write_data_1 (ram_write_data_1),
        .ib_ram_we        (ib_ram_we)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int unsigned c; logic [8:0] a; logic [1:0] d; } ev_t;
    typedef struct { int unsigned s; int unsigned e; } iv_t;

    ev_t         fe_q[$];
    ev_t         wr_q[$];
    int unsigned done_q[$];
    int unsigned err_q[$];
    int unsigned drop_q[$];
    iv_t         busy_q[$];

    logic [1:0] rom_mem [512];
    int  lat = 1;
    bit  stray_en = 1'b0;
    bit  mon_en = 1'b0;
    int  cnt = 0;
    logic [1:0] pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ROM model with latency lat; optional stray valids outside the wait window.
    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            rom_rd_valid = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
            rom_rd_valid = (cnt == 0);
            if (cnt == 0) rom_rd_data = pend_data;
        end else begin
            if (rom_rd_en) begin
                cnt = lat;
                pend_data = rom_mem[rom_rd_addr];
            end
            if (stray_en && $urandom_range(0, 2) == 0) begin
                rom_rd_valid = 1'b1;
                rom_rd_data = 2'($urandom);
            end else begin
                rom_rd_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            ev_t e;
            int unsigned c;
            if (rom_rd_en) begin
                if (fe_q.size() == 0) check("rom_rd_en_unexpected", 1, 0);
                else begin
                    e = fe_q.pop_front();
                    check("fetch_cycle", cyc, e.c);
                    check("fetch_addr", 32'(rom_rd_addr), 32'(e.a));
                end
            end
            if (ib_ram_we) begin
                if (wr_q.size() == 0) check("ram_we_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check("write_cycle", cyc, e.c);
                    check("write_addr", 32'(page_addr_ram), 32'(e.a));
                    check("write_data", 32'(ram_write_data_1), 32'(e.d));
                end
            end
            if (update_done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin c = done_q.pop_front(); check("done_cycle", cyc, c); end
            end
            if (iter_err) begin
                if (err_q.size() == 0) check("iter_err_unexpected", 1, 0);
                else begin c = err_q.pop_front(); check("iter_err_cycle", cyc, c); end
            end
            if (req_dropped) begin
                if (drop_q.size() == 0) check("req_dropped_unexpected", 1, 0);
                else begin c = drop_q.pop_front(); check("req_dropped_cycle", cyc, c); end
            end
            exp_busy = 1'b0;
            foreach (busy_q[i]) if (cyc >= busy_q[i].s && cyc <= busy_q[i].e) exp_busy = 1'b1;
            check("busy", 32'(update_busy), 32'(exp_busy));
            check("we_en_exclusive", 32'(rom_rd_en & ib_ram_we), 0);
        end
    end

    // Expected activity of an accepted update started at cycle t0, truncated at cycle stop.
    task automatic push_update(input int unsigned t0, input int i, input int f, input int l,
                               input int unsigned stop);
        int unsigned fc, wc, dc;
        for (int p = 0; p < PAGES; p++) begin
            fc = t0 + 1 + p * (l + 2);
            wc = fc + l + 1;
            if (fc <= stop) fe_q.push_back('{c: fc, a: 9'(i * 16 + p), d: 2'b0});
            if (wc <= stop) wr_q.push_back('{c: wc, a: 9'(f * 16 + p), d: rom_mem[i * 16 + p]});
        end
        dc = t0 + 1 + PAGES * (l + 2);
        if (dc <= stop) done_q.push_back(dc);
        busy_q.push_back('{s: t0 + 1, e: (dc < stop) ? dc : stop});
    endtask

    task automatic drive_req(input int i, input int f);
        update_req = 1'b1;
        update_iter = 5'(i);
        update_frame = 1'(f);
        @(negedge clk);
        update_req = 1'b0;
    endtask

    task automatic run_full(input int i, input int f, input int l);
        int unsigned t0;
        t0 = cyc;
        lat = l;
        push_update(t0, i, f, l, NEVER);
        drive_req(i, f);
        while (cyc < t0 + 2 + PAGES * (l + 2)) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(update_busy), 0);
        check({tag, "_done"}, 32'(update_done), 0);
        check({tag, "_iter_err"}, 32'(iter_err), 0);
        check({tag, "_dropped"}, 32'(req_dropped), 0);
        check({tag, "_rom_en"}, 32'(rom_rd_en), 0);
        check({tag, "_rom_addr"}, 32'(rom_rd_addr), 0);
        check({tag, "_ram_addr"}, 32'(page_addr_ram), 0);
        check({tag, "_ram_data"}, 32'(ram_write_data_1), 0);
        check({tag, "_we"}, 32'(ib_ram_we), 0);
    endtask

    initial begin
        int unsigned t0, r, dc;
        int i, f;
        foreach (rom_mem[k]) rom_mem[k] = 2'($urandom);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // 1: iter 3, frame 1, latency 1
        run_full(3, 1, 1);

        // 2: iter 0, frame 0, latency 4
        run_full(0, 0, 4);

        // 3: out-of-range iteration
        err_q.push_back(cyc + 1);
        drive_req(10, 1);
        repeat (5) @(negedge clk);
        drive_req(31, 0);
        err_q.push_back(cyc);
        repeat (5) @(negedge clk);

        // 4: request during page 5 is dropped; request right after done is accepted
        i = $urandom_range(0, 9);
        f = $urandom_range(0, 1);
        t0 = cyc;
        lat = 2;
        push_update(t0, i, f, 2, NEVER);
        drive_req(i, f);
        r = t0 + 1 + 5 * 4 + 1;
        while (cyc < r) @(negedge clk);
        drop_q.push_back(r + 1);
        drive_req($urandom_range(0, 9), 1 - f);
        dc = t0 + 1 + PAGES * 4;
        while (cyc < dc) @(negedge clk);
        drop_q.push_back(dc + 1);
        drive_req($urandom_range(0, 9), 0);
        run_full($urandom_range(0, 9), $urandom_range(0, 1), 1);

        // 5: reset during WAIT of page 7
        i = $urandom_range(0, 9);
        f = $urandom_range(0, 1);
        t0 = cyc;
        lat = 3;
        r = t0 + 1 + 7 * 5 + 1;
        push_update(t0, i, f, 3, r);
        drive_req(i, f);
        while (cyc < r) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run_full($urandom_range(0, 9), $urandom_range(0, 1), 2);

        // 6: stray valids with the highest legal iteration
        stray_en = 1'b1;
        repeat (4) @(negedge clk);
        run_full(9, 1, $urandom_range(1, 3));
        run_full($urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(1, 4));
        stray_en = 1'b0;

        repeat (8) @(negedge clk);
        check("pending_fetches", fe_q.size(), 0);
        check("pending_writes", wr_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        check("pending_iter_err", err_q.size(), 0);
        check("pending_dropped", drop_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
